rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
Write-port scheduler and hazard scoreboard for the 16-entry x 16-bit register file. Two writeback sources share the file's single write port under round-robin arbitration: source 0 is the ALU, source 1 is the load unit. A per-register pending scoreboard is set at issue and cleared at writeback, and it generates the issue stall for RAW/WAW hazards. The block sits between the issue stage, the execution units and the register file write port (we / w_addr / w_data).

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width; register count is 2**ADDR_W

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
s0_valid  in  1  ALU writeback request
s0_ready  out  1  ALU writeback grant (combinational)
s0_addr  in  ADDR_W  ALU destination register
s0_data  in  DATA_W  ALU result
s1_valid  in  1  load-unit writeback request
s1_ready  out  1  load-unit writeback grant (combinational)
s1_addr  in  ADDR_W  load destination register
s1_data  in  DATA_W  load data
iss_valid  in  1  issue stage presents an instruction
iss_src1  in  ADDR_W  first source register
iss_src2  in  ADDR_W  second source register
iss_dst  in  ADDR_W  destination register
iss_wr  in  1  instruction writes iss_dst
iss_stall  out  1  hazard present; the instruction must not issue this cycle (combinational)
rf_we  out  1  register file write enable (registered)
rf_w_addr  out  ADDR_W  register file write address (registered)
rf_w_data  out  DATA_W  register file write data (registered)
idle  out  1  no pending bits set and rf_we low
wb_err  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (async, rst_n low): pending[] = 0, rr_last = 1 (source 0 wins first contention), rf_we = 0, rf_w_addr = 0, rf_w_data = 0, wb_err = 0. Outputs take these values immediately and hold them until release.
- Arbitration:
  - One grant per cycle.
  - Only one valid: that source gets ready = 1.
  - Both valid: grant the source not recorded in rr_last.
  - rr_last updates only on an accepted transfer (valid && ready).
  - The ungranted source holds valid, addr and data stable until granted (no-drop rule).
- Write latency: a transfer accepted at edge N drives rf_we = 1 with the captured addr/data during cycle N+1. The register file writes at edge N+1. rf_we is low in any cycle after an edge with no transfer. Back-to-back writes at full rate are allowed.
- Scoreboard:
  - pending[a] sets at an edge where iss_valid && !iss_stall && iss_wr, with a = iss_dst.
  - pending[a] clears at the edge that completes the register file write, i.e. the edge ending a cycle with rf_we = 1 and rf_w_addr = a.
- Hazard detection:
  - iss_stall = iss_valid && (pending[iss_src1] || pending[iss_src2] || (iss_wr && pending[iss_dst])).
  - No bypass: a register is readable without stall only after its clear edge.
- Simultaneous clear and set on the same register at one edge: set wins, so pending stays 1.
- Writeback to a non-pending register:
  - On acceptance with pending[addr] = 0, wb_err sets and stays set until reset.
  - The write is still performed.
- Both sources targeting the same register in one cycle: arbitrated normally; the second write sets wb_err because the first clears pending.
- Reset mid-operation: any in-flight rf_we is dropped and all pending bits are lost. Execution units are flushed by the same reset.
- idle = (pending == 0) && !rf_we.

Test Plan:
1. Reset, then s0 writes r3 = 0x1234 with pending[3] preset via issue -> s0_ready=1 the same cycle; next cycle rf_we=1, rf_w_addr=3, rf_w_data=0x1234; pending[3]=0 after the following edge; idle=1.
2. Issue dst=r5 (iss_wr=1), then issue src1=r5 -> second issue has iss_stall=1 until the edge after rf_we with rf_w_addr=5; at that edge iss_stall drops to 0.
3. s0 and s1 both valid for 4 cycles (distinct pending dsts r1..r4) -> grants alternate s0, s1, s0, s1; rf_we high for 4 consecutive cycles with matching addr/data order.
4. Same-edge clear of r7 and new issue with dst=r7 -> pending[7] stays 1; a subsequent read of r7 stalls.
5. s1 writes r9 with pending[9]=0 -> wb_err=1 and stays 1; rf_we=1, rf_w_addr=9 still occurs; wb_err returns to 0 only on rst_n low.
6. Assert rst_n low during the cycle rf_we=1 -> rf_we=0 immediately; all pending bits 0; after release, s0 wins the first contention.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler and RAW/WAW hazard scoreboard for the register file:
// round-robin between ALU (source 0) and load unit (source 1), one registered write per cycle.
module rf_wb_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_src1,
  input  logic [ADDR_W-1:0] iss_src2,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              iss_wr,
  output logic              iss_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              idle,
  output logic              wb_err
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;
  logic              rr_last;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              issue_set;
  logic              xfer_pending;

  // rr_last names the source granted most recently; under contention the other one wins.
  always_comb begin
    grant0    = s0_valid && (!s1_valid || rr_last);
    grant1    = s1_valid && (!s0_valid || !rr_last);
    xfer      = grant0 || grant1;
    xfer_addr = grant1 ? s1_addr : s0_addr;
    xfer_data = grant1 ? s1_data : s0_data;
  end

  assign s0_ready  = grant0;
  assign s1_ready  = grant1;
  assign iss_stall = iss_valid &&
                     (pending[iss_src1] || pending[iss_src2] || (iss_wr && pending[iss_dst]));
  assign issue_set = iss_valid && !iss_stall && iss_wr;
  assign idle      = (pending == '0) && !rf_we;

  // A register whose write is completing this cycle already counts as not pending,
  // so a second writeback to the same register is flagged.
  assign xfer_pending = pending[xfer_addr] && !(rf_we && (rf_w_addr == xfer_addr));

  // Clear is applied before set so an issue landing on the clear edge keeps the bit.
  always_comb begin
    pending_next = pending;
    if (rf_we) begin
      pending_next[rf_w_addr] = 1'b0;
    end
    if (issue_set) begin
      pending_next[iss_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      rr_last   <= 1'b1;
      rf_we     <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      wb_err    <= 1'b0;
    end else begin
      pending <= pending_next;
      rf_we   <= xfer;
      if (xfer) begin
        rf_w_addr <= xfer_addr;
        rf_w_data <= xfer_data;
        rr_last   <= grant1;
        if (!xfer_pending) begin
          wb_err <= 1'b1;
        end
      end
    end
  end

endmodule
